// File: rtl/mmio_arbiter.sv
// Two-port arbiter sharing the MMIO register block port between CPU (req0) and debug/loader (req1).
// Define MMIO_ARB_FIXED_PRIO_EN for fixed priority to req0; default is round-robin.
module mmio_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_W-1:0]     req0_address,
  input  logic [DATA_W/8-1:0]   req0_byteena,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req0_wren,
  output logic                  rsp0_valid,
  output logic [DATA_W-1:0]     rsp0_q,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_W-1:0]     req1_address,
  input  logic [DATA_W/8-1:0]   req1_byteena,
  input  logic [DATA_W-1:0]     req1_data,
  input  logic                  req1_wren,
  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp1_q,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteena,
  output logic [DATA_W-1:0]     data,
  output logic                  wren,
  output logic                  clken,
  input  logic [DATA_W-1:0]     q
);

  logic                grant0;
  logic                grant1;
  logic                issue;
  logic [ADDR_W-1:0]   address_q;
  logic [DATA_W/8-1:0] byteena_q;
  logic [DATA_W-1:0]   data_q;
  logic [LAT-1:0]      pipe_vld;
  logic [LAT-1:0]      pipe_id;
  logic [LAT-1:0]      pipe_rd;
  logic                out_vld;
  logic                out_id;
  logic                out_rd;

`ifndef MMIO_ARB_FIXED_PRIO_EN
  typedef enum logic {RR_REQ0 = 1'b0, RR_REQ1 = 1'b1} rr_t;
  rr_t rr_ptr;
`endif

  // Grants are masked while reset is asserted so every output reads 0 in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      grant0 = req0_valid && (!req1_valid || rr_ptr == RR_REQ0);
      grant1 = req1_valid && (!req0_valid || rr_ptr == RR_REQ1);
`endif
    end
  end

  assign issue      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign clken      = issue;

  always_comb begin
    address = address_q;
    byteena = byteena_q;
    data    = data_q;
    wren    = 1'b0;
    if (grant1) begin
      address = req1_address;
      byteena = req1_byteena;
      data    = req1_data;
      wren    = req1_wren;
    end else if (grant0) begin
      address = req0_address;
      byteena = req0_byteena;
      data    = req0_data;
      wren    = req0_wren;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_q <= '0;
      byteena_q <= '0;
      data_q    <= '0;
      pipe_vld  <= '0;
      pipe_id   <= '0;
      pipe_rd   <= '0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
      rr_ptr    <= RR_REQ0;
`endif
    end else begin
      if (issue) begin
        address_q <= address;
        byteena_q <= byteena;
        data_q    <= data;
      end
`ifndef MMIO_ARB_FIXED_PRIO_EN
      if (grant0)
        rr_ptr <= RR_REQ1;
      else if (grant1)
        rr_ptr <= RR_REQ0;
`endif
      pipe_vld[0] <= issue;
      pipe_id[0]  <= grant1;
      pipe_rd[0]  <= issue && !wren;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_rd[i]  <= pipe_rd[i-1];
      end
    end
  end

  assign out_vld = pipe_vld[LAT-1];
  assign out_id  = pipe_id[LAT-1];
  assign out_rd  = pipe_rd[LAT-1];

  assign rsp0_valid = out_vld && !out_id;
  assign rsp1_valid = out_vld && out_id;
  assign rsp0_q     = (rsp0_valid && out_rd) ? q : '0;
  assign rsp1_q     = (rsp1_valid && out_rd) ? q : '0;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: a LAT=1 and a LAT=3 instance share requester stimulus,
// each in front of its own small MMIO register model (16 words, out-of-range reads return 0).
module tb_mmio_arbiter;

`ifdef MMIO_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid, req1_valid, req0_wren, req1_wren;
  logic [13:0] req0_address, req1_address;
  logic [3:0]  req0_byteena, req1_byteena;
  logic [31:0] req0_data, req1_data;

  logic        req0_ready_a, req1_ready_a, rsp0_valid_a, rsp1_valid_a, wren_a, clken_a;
  logic [31:0] rsp0_q_a, rsp1_q_a, data_a, q_a;
  logic [13:0] address_a;
  logic [3:0]  byteena_a;
  logic        req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b, wren_b, clken_b;
  logic [31:0] rsp0_q_b, rsp1_q_b, data_b, q_b;
  logic [13:0] address_b;
  logic [3:0]  byteena_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mmio_arbiter #(.ADDR_W(14), .DATA_W(32), .LAT(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_a), .req0_address(req0_address),
    .req0_byteena(req0_byteena), .req0_data(req0_data), .req0_wren(req0_wren),
    .rsp0_valid(rsp0_valid_a), .rsp0_q(rsp0_q_a),
    .req1_valid(req1_valid), .req1_ready(req1_ready_a), .req1_address(req1_address),
    .req1_byteena(req1_byteena), .req1_data(req1_data), .req1_wren(req1_wren),
    .rsp1_valid(rsp1_valid_a), .rsp1_q(rsp1_q_a),
    .address(address_a), .byteena(byteena_a), .data(data_a), .wren(wren_a),
    .clken(clken_a), .q(q_a));

  mmio_arbiter #(.ADDR_W(14), .DATA_W(32), .LAT(3)) u_dut_b (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_b), .req0_address(req0_address),
    .req0_byteena(req0_byteena), .req0_data(req0_data), .req0_wren(req0_wren),
    .rsp0_valid(rsp0_valid_b), .rsp0_q(rsp0_q_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_b), .req1_address(req1_address),
    .req1_byteena(req1_byteena), .req1_data(req1_data), .req1_wren(req1_wren),
    .rsp1_valid(rsp1_valid_b), .rsp1_q(rsp1_q_b),
    .address(address_b), .byteena(byteena_b), .data(data_b), .wren(wren_b),
    .clken(clken_b), .q(q_b));

  // Register models: word i powers up as 0x100 + 0x11*i.
  logic        mem_init = 1'b0;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] pipe_b [3];

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= 32'h100 + 32'h11 * i;
        mem_b[i] <= 32'h100 + 32'h11 * i;
      end
      for (int i = 0; i < 3; i++) pipe_b[i] <= '0;
      q_a      <= '0;
      mem_init <= 1'b1;
    end else begin
      if (clken_a) begin
        q_a <= (address_a < 14'd16) ? mem_a[address_a[3:0]] : '0;
        if (wren_a && address_a < 14'd16)
          for (int b = 0; b < 4; b++)
            if (byteena_a[b]) mem_a[address_a[3:0]][8*b +: 8] <= data_a[8*b +: 8];
      end
      pipe_b[0] <= (clken_b && address_b < 14'd16) ? mem_b[address_b[3:0]] : '0;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
      if (clken_b && wren_b && address_b < 14'd16)
        for (int b = 0; b < 4; b++)
          if (byteena_b[b]) mem_b[address_b[3:0]][8*b +: 8] <= data_b[8*b +: 8];
    end
  end
  assign q_b = pipe_b[2];

  typedef struct {
    logic v0; logic [13:0] a0; logic [3:0] be0; logic [31:0] d0; logic w0;
    logic v1; logic [13:0] a1; logic [3:0] be1; logic [31:0] d1; logic w1;
    logic e_r0; logic e_r1; logic e_ck; logic e_wr;
    logic [13:0] e_addr; logic [3:0] e_be; logic [31:0] e_d;
    logic e_v0; logic [31:0] e_q0; logic e_v1; logic [31:0] e_q1;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [13:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic w0,
                       input logic v1, input logic [13:0] a1, input logic [3:0] be1,
                       input logic [31:0] d1, input logic w1);
    req0_valid = v0; req0_address = a0; req0_byteena = be0; req0_data = d0; req0_wren = w0;
    req1_valid = v1; req1_address = a1; req1_byteena = be1; req1_data = d1; req1_wren = w1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  int eg [10];
  int prev_a, prev_b, cnt0_a, cnt1_a, cnt0_b, cnt1_b;
  logic [31:0] lat3_q [3];

  initial begin
    idle();
    // Reset state with a pending request: nothing may be granted.
    req0_valid = 1'b1;
    #12;
    chk("rst_ready0", {31'b0, req0_ready_a}, 32'd0);
    chk("rst_clken", {31'b0, clken_a}, 32'd0);
    chk("rst_wren", {31'b0, wren_a}, 32'd0);
    chk("rst_address", {18'b0, address_a}, 32'd0);
    chk("rst_rsp", {30'b0, rsp0_valid_a, rsp1_valid_a}, 32'd0);
    idle();
    @(posedge clock); #1;
    reset_n = 1'b1;

    //             v0 a0      be0   d0            w0  v1 a1     be1   d1    w1   r0 r1 ck wr addr     be    data          v0 q0        v1 q1
    vec[0]  = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b0,1'b0,1'b0,1'b0, 14'h0,    4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vec[1]  = '{1'b1, 14'h1, 4'h3, 32'h3FF,      1'b1, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b1,1'b0,1'b1,1'b1, 14'h1,    4'h3, 32'h3FF,      1'b0, 32'h0,        1'b0, 32'h0};
    vec[2]  = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b0,1'b0,1'b0,1'b0, 14'h1,    4'h3, 32'h3FF,      1'b1, 32'h0,        1'b0, 32'h0};
    vec[3]  = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b1, 14'h1, 4'hF, 32'h0, 1'b0, 1'b0,1'b1,1'b1,1'b0, 14'h1,    4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vec[4]  = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b0,1'b0,1'b0,1'b0, 14'h1,    4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'h3FF};
    vec[5]  = '{1'b1, 14'h5, 4'hF, 32'h0,        1'b0, 1'b1, 14'h0, 4'hF, 32'h0, 1'b0, 1'b1,1'b0,1'b1,1'b0, 14'h5,    4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vec[6]  = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b1, 14'h0, 4'hF, 32'h0, 1'b0, 1'b0,1'b1,1'b1,1'b0, 14'h0,    4'hF, 32'h0,        1'b1, 32'h155,      1'b0, 32'h0};
    vec[7]  = '{1'b1, 14'h2, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b1,1'b0,1'b1,1'b1, 14'h2,    4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 32'h100};
    vec[8]  = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b1, 14'h2, 4'hF, 32'h0, 1'b0, 1'b0,1'b1,1'b1,1'b0, 14'h2,    4'hF, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vec[9]  = '{1'b1, 14'h3FFF,4'hF,32'h0,       1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b1,1'b0,1'b1,1'b0, 14'h3FFF, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    vec[10] = '{1'b0, 14'h0, 4'h0, 32'h0,        1'b0, 1'b0, 14'h0, 4'h0, 32'h0, 1'b0, 1'b0,1'b0,1'b0,1'b0, 14'h3FFF, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      @(posedge clock); #1;
      drive(vec[i].v0, vec[i].a0, vec[i].be0, vec[i].d0, vec[i].w0,
            vec[i].v1, vec[i].a1, vec[i].be1, vec[i].d1, vec[i].w1);
      #3;
      chk($sformatf("v%0d_ready0", i), {31'b0, req0_ready_a}, {31'b0, vec[i].e_r0});
      chk($sformatf("v%0d_ready1", i), {31'b0, req1_ready_a}, {31'b0, vec[i].e_r1});
      chk($sformatf("v%0d_clken", i), {31'b0, clken_a}, {31'b0, vec[i].e_ck});
      chk($sformatf("v%0d_wren", i), {31'b0, wren_a}, {31'b0, vec[i].e_wr});
      chk($sformatf("v%0d_address", i), {18'b0, address_a}, {18'b0, vec[i].e_addr});
      chk($sformatf("v%0d_byteena", i), {28'b0, byteena_a}, {28'b0, vec[i].e_be});
      chk($sformatf("v%0d_data", i), data_a, vec[i].e_d);
      chk($sformatf("v%0d_rsp0_valid", i), {31'b0, rsp0_valid_a}, {31'b0, vec[i].e_v0});
      chk($sformatf("v%0d_rsp0_q", i), rsp0_q_a, vec[i].e_q0);
      chk($sformatf("v%0d_rsp1_valid", i), {31'b0, rsp1_valid_a}, {31'b0, vec[i].e_v1});
      chk($sformatf("v%0d_rsp1_q", i), rsp1_q_a, vec[i].e_q1);
    end

    // Reset mid-flight: a read issued just before the async pulse must never respond.
    @(posedge clock); #1;
    drive(1'b1, 14'h1, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    #3;
    chk("midrst_issue", {31'b0, req0_ready_a}, 32'd1);
    @(posedge clock); #1;
    idle();
    chk("midrst_pre_rsp0", {31'b0, rsp0_valid_a}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_cleared", {30'b0, rsp0_valid_a, rsp1_valid_a}, 32'd0);
    chk("midrst_address", {18'b0, address_a}, 32'd0);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #4;
      chk($sformatf("midrst_quiet_a%0d", k), {30'b0, rsp0_valid_a, rsp1_valid_a}, 32'd0);
      chk($sformatf("midrst_quiet_b%0d", k), {30'b0, rsp0_valid_b, rsp1_valid_b}, 32'd0);
    end

    // Both valid for 6 cycles right after reset: alternation starts with req0.
    for (int k = 0; k < 10; k++) eg[k] = (k < 6) ? (FIXED ? 0 : k % 2) : -1;
    cnt0_a = 0; cnt1_a = 0; cnt0_b = 0; cnt1_b = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (k < 6) drive(1'b1, 14'h3, 4'hF, 32'h0, 1'b0, 1'b1, 14'h4, 4'hF, 32'h0, 1'b0);
      else idle();
      #3;
      prev_a = (k >= 1) ? eg[k-1] : -1;
      prev_b = (k >= 3) ? eg[k-3] : -1;
      cnt0_a += int'(rsp0_valid_a); cnt1_a += int'(rsp1_valid_a);
      cnt0_b += int'(rsp0_valid_b); cnt1_b += int'(rsp1_valid_b);
      chk($sformatf("alt%0d_ready0", k), {31'b0, req0_ready_a}, (eg[k] == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_ready1", k), {31'b0, req1_ready_a}, (eg[k] == 1) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_rsp0_a", k), rsp0_q_a, (prev_a == 0) ? 32'h133 : 32'h0);
      chk($sformatf("alt%0d_rsp1_a", k), rsp1_q_a, (prev_a == 1) ? 32'h144 : 32'h0);
      chk($sformatf("alt%0d_rsp0_b", k), {31'b0, rsp0_valid_b}, (prev_b == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_rsp1_b", k), {31'b0, rsp1_valid_b}, (prev_b == 1) ? 32'd1 : 32'd0);
    end
    chk("alt_cnt0_a", cnt0_a, FIXED ? 32'd6 : 32'd3);
    chk("alt_cnt1_a", cnt1_a, FIXED ? 32'd0 : 32'd3);
    chk("alt_cnt0_b", cnt0_b, FIXED ? 32'd6 : 32'd3);
    chk("alt_cnt1_b", cnt1_b, FIXED ? 32'd0 : 32'd3);

    // LAT=3 instance: three back-to-back reads return in order three cycles later.
    lat3_q[0] = 32'h100; lat3_q[1] = 32'h3FF; lat3_q[2] = 32'h155;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      case (k)
        0: drive(1'b1, 14'h0, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        1: drive(1'b1, 14'h1, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        2: drive(1'b1, 14'h5, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        default: idle();
      endcase
      #3;
      chk($sformatf("lat3_%0d_valid", k), {31'b0, rsp0_valid_b}, (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("lat3_%0d_q", k), rsp0_q_b, (k >= 3 && k <= 5) ? lat3_q[k-3] : 32'h0);
      chk($sformatf("lat3_%0d_rsp1", k), {31'b0, rsp1_valid_b}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
